// File: rtl/framebuffer_dbuf_if.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_dbuf_if
// Brief    : CPU port, scanout port, flip and clear signals of framebuffer_dbuf.
// Revision : 1.0
// ============================================================================
interface framebuffer_dbuf_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int DEPTH_A     = 4096
);
    localparam int LANES        = DATA_WIDTH / 8;
    localparam int RATIO        = DATA_WIDTH / PIXEL_WIDTH;
    localparam int DEPTH_B      = DEPTH_A * RATIO;
    localparam int ADDR_WIDTH_A = $clog2(DEPTH_A);
    localparam int ADDR_WIDTH_B = $clog2(DEPTH_B);

    logic                    wr_a;
    logic [LANES-1:0]        mask_a;
    logic [ADDR_WIDTH_A-1:0] addr_a;
    logic [DATA_WIDTH-1:0]   data_a;
    logic [DATA_WIDTH-1:0]   q_a;
    logic [ADDR_WIDTH_B-1:0] addr_b;
    logic [PIXEL_WIDTH-1:0]  q_b;
    logic                    vblank;
    logic                    flip_req;
    logic                    flip_pending;
    logic                    front_page;
    logic                    clear_start;
    logic [DATA_WIDTH-1:0]   clear_value;
    logic                    clear_busy;

    modport master (
        output wr_a, mask_a, addr_a, data_a, addr_b, vblank, flip_req,
               clear_start, clear_value,
        input  q_a, q_b, flip_pending, front_page, clear_busy
    );

    modport slave (
        input  wr_a, mask_a, addr_a, data_a, addr_b, vblank, flip_req,
               clear_start, clear_value,
        output q_a, q_b, flip_pending, front_page, clear_busy
    );
endinterface
`default_nettype wire

// File: rtl/framebuffer_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_dbuf
// Brief    : Double-buffered framebuffer with vblank-synchronised page flip and
//            optional back-page clear engine (enabled by macro FB_CLEAR_EN).
// Revision : 1.0
// ============================================================================
module framebuffer_dbuf #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int DEPTH_A     = 4096
) (
    input  wire logic          clk,
    input  wire logic          reset,
    framebuffer_dbuf_if.slave  bus
);
    localparam int LANES        = DATA_WIDTH / 8;
    localparam int RATIO        = DATA_WIDTH / PIXEL_WIDTH;
    localparam int DEPTH_B      = DEPTH_A * RATIO;
    localparam int ADDR_WIDTH_A = $clog2(DEPTH_A);
    localparam int ADDR_WIDTH_B = $clog2(DEPTH_B);
    localparam int SUB_BITS     = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                    front_q, front_d;
    logic                    pending_q, pending_d;
    logic                    clear_busy;
    logic [ADDR_WIDTH_A-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [LANES-1:0]        wr_en;
    logic [ADDR_WIDTH_A-1:0] word_b;
    logic [SUB_BITS-1:0]     sub_b;
    logic [SUB_BITS-1:0]     sub_q;
    logic [DATA_WIDTH-1:0]   qa_word;
    logic [DATA_WIDTH-1:0]   qb_word;
    logic [PIXEL_WIDTH-1:0]  qb_pixel;

    // Flip control: a pending flip waits for vblank and for any clear to finish.
    always_comb begin
        front_d   = front_q;
        pending_d = pending_q;
        if (pending_q && bus.vblank && !clear_busy) begin
            front_d   = ~front_q;
            pending_d = bus.flip_req;
        end else if (bus.flip_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            front_q   <= front_d;
            pending_q <= pending_d;
        end
    end

`ifdef FB_CLEAR_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH_A-1:0] LAST_WORD = ADDR_WIDTH_A'(DEPTH_A - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH_A-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   cval_q, cval_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cval_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cval_q  <= cval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cval_d  = cval_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    cval_d  = bus.clear_value;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign clear_busy = (state_q == S_CLEAR);
    assign wr_addr    = clear_busy ? cnt_q  : bus.addr_a;
    assign wr_data    = clear_busy ? cval_q : bus.data_a;
    // A reset landing mid-clear must not write the word the engine points at.
    assign wr_en      = clear_busy ? (reset ? '0 : '1)
                                   : (bus.wr_a ? bus.mask_a : '0);
`else
    logic w_unused_clear;

    assign w_unused_clear = bus.clear_start ^ (^bus.clear_value);
    assign clear_busy     = 1'b0;
    assign wr_addr        = bus.addr_a;
    assign wr_data        = bus.data_a;
    assign wr_en          = bus.wr_a ? bus.mask_a : '0;
`endif

    generate
        if (RATIO > 1) begin : g_subword
            assign word_b = bus.addr_b[ADDR_WIDTH_B-1:SUB_BITS];
            assign sub_b  = bus.addr_b[SUB_BITS-1:0];
        end else begin : g_fullword
            assign word_b = bus.addr_b;
            assign sub_b  = '0;
        end
    endgenerate

    // Writes and port A reads target the back page as seen before this edge.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] mem [2*DEPTH_A];
            logic [7:0] qa_q;
            logic [7:0] qb_q;

            always_ff @(posedge clk) begin
                if (wr_en[l]) begin
                    mem[{~front_q, wr_addr}] <= wr_data[8*l +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    qa_q <= '0;
                    qb_q <= '0;
                end else begin
                    qa_q <= mem[{~front_q, bus.addr_a}];
                    qb_q <= mem[{front_q, word_b}];
                end
            end

            assign qa_word[8*l +: 8] = qa_q;
            assign qb_word[8*l +: 8] = qb_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub_b;
        end
    end

    always_comb begin
        qb_pixel = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sub_q == i[SUB_BITS-1:0]) begin
                qb_pixel = qb_word[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    assign bus.q_a          = qa_word;
    assign bus.q_b          = qb_pixel;
    assign bus.flip_pending = pending_q;
    assign bus.front_page   = front_q;
    assign bus.clear_busy   = clear_busy;
endmodule
`default_nettype wire

// File: tb/tb_framebuffer_dbuf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_framebuffer_dbuf
// Brief    : Directed scoreboard bench for framebuffer_dbuf (DEPTH_A = 16).
// Revision : 1.0
// ============================================================================
module tb_framebuffer_dbuf;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam int DA = 16;

    localparam int QA = 0;
    localparam int QB = 1;
    localparam int FR = 2;
    localparam int PD = 3;
    localparam int BZ = 4;

    typedef struct {
        int          due;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    framebuffer_dbuf_if #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .DEPTH_A(DA)) bus ();

    framebuffer_dbuf #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .DEPTH_A(DA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] actual(input int sig);
        case (sig)
            QA:      return bus.q_a;
            QB:      return {8'h00, bus.q_b};
            FR:      return {15'd0, bus.front_page};
            PD:      return {15'd0, bus.flip_pending};
            default: return {15'd0, bus.clear_busy};
        endcase
    endfunction

    function automatic string sname(input int sig);
        case (sig)
            QA:      return "q_a";
            QB:      return "q_b";
            FR:      return "front_page";
            PD:      return "flip_pending";
            default: return "clear_busy";
        endcase
    endfunction

    // Monitor: compares every queued expectation whose due cycle has arrived.
    always @(negedge clk) begin
        exp_t        keep[$];
        logic [15:0] a;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                a = actual(sb[i].sig);
                checks++;
                if (a !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %h expected %h",
                             sname(sb[i].sig), cyc, a, sb[i].exp);
                end
            end else if (sb[i].due < cyc) begin
                errors++;
                $display("FAIL %s expectation for cycle %0d never sampled",
                         sname(sb[i].sig), sb[i].due);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic expect_v(input int sig, input logic [15:0] v, input int lat = 1);
        exp_t e;
        e.due = cyc + lat;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drv_wr(input int a, input logic [15:0] d, input logic [1:0] m);
        bus.wr_a   = 1'b1;
        bus.addr_a = a[3:0];
        bus.data_a = d;
        bus.mask_a = m;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        bus.wr_a        = 1'b0;
        bus.mask_a      = '0;
        bus.addr_a      = '0;
        bus.data_a      = '0;
        bus.addr_b      = '0;
        bus.vblank      = 1'b0;
        bus.flip_req    = 1'b0;
        bus.clear_start = 1'b0;
        bus.clear_value = '0;

        tick(); tick();
        expect_v(QA, 16'h0000); expect_v(QB, 16'h0000); expect_v(FR, 16'h0);
        expect_v(PD, 16'h0);    expect_v(BZ, 16'h0);
        tick(); reset = 1'b0;

        // Masked write and read-during-write on the back page (page 1)
        tick(); drv_wr(3, 16'h1111, 2'b11);
        tick(); drv_wr(3, 16'hABCD, 2'b01); expect_v(QA, 16'h1111);
        tick(); bus.wr_a = 1'b0; bus.addr_a = 4'd3; expect_v(QA, 16'h11CD);

        // Scanout after a flip; write in the flip cycle lands in the old back page
        tick(); drv_wr(5, 16'h1234, 2'b11);
        tick(); bus.wr_a = 1'b0; bus.flip_req = 1'b1; bus.vblank = 1'b1; expect_v(PD, 16'h1);
        tick(); bus.flip_req = 1'b0; drv_wr(6, 16'h7777, 2'b11);
        expect_v(FR, 16'h1); expect_v(PD, 16'h0);
        tick(); bus.wr_a = 1'b0; bus.addr_b = 5'd10; expect_v(QB, 16'h0034);
        tick(); bus.addr_b = 5'd11; expect_v(QB, 16'h0012);
        tick(); bus.addr_b = 5'd13; expect_v(QB, 16'h0077);

        // Flip gated by vblank; repeated requests do not queue
        tick(); bus.vblank = 1'b0; bus.flip_req = 1'b1; expect_v(PD, 16'h1);
        tick(); bus.flip_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(); bus.flip_req = (k == 10);
            expect_v(PD, 16'h1); expect_v(FR, 16'h1);
        end
        tick(); bus.flip_req = 1'b0; bus.vblank = 1'b1;
        expect_v(FR, 16'h0); expect_v(PD, 16'h0);

        // Request in the swap cycle re-arms the flip
        tick(); bus.flip_req = 1'b1; expect_v(PD, 16'h1); expect_v(FR, 16'h0);
        tick(); bus.flip_req = 1'b1; expect_v(FR, 16'h1); expect_v(PD, 16'h1);
        tick(); bus.flip_req = 1'b0; bus.vblank = 1'b0; expect_v(FR, 16'h1); expect_v(PD, 16'h1);
        tick(); bus.vblank = 1'b1; expect_v(FR, 16'h0); expect_v(PD, 16'h0);
        tick(); bus.vblank = 1'b0;

`ifdef FB_CLEAR_EN
        // Clear back page (page 1): busy exactly DA cycles, CPU writes dropped
        tick(); bus.clear_start = 1'b1; bus.clear_value = 16'h5A5A;
        for (int k = 1; k <= DA; k++) expect_v(BZ, 16'h1, k);
        expect_v(BZ, 16'h0, DA + 1);
        tick(); bus.clear_start = 1'b0; bus.clear_value = 16'hFFFF;
        for (int k = 0; k < DA; k++) begin
            drv_wr(15 - k, 16'hDEAD, 2'b11);
            bus.clear_start = (k == 4);
            tick();
        end
        bus.wr_a = 1'b0; bus.clear_start = 1'b0;
        for (int w = 0; w < DA; w++) begin
            tick(); bus.addr_a = w[3:0]; expect_v(QA, 16'h5A5A);
        end

        // Flip requested during a clear waits until the clear completes
        tick(); bus.clear_start = 1'b1; bus.clear_value = 16'h3C3C; bus.vblank = 1'b1;
        tick(); bus.clear_start = 1'b0;
        tick(); bus.flip_req = 1'b1;
        expect_v(PD, 16'h1, 1);  expect_v(FR, 16'h0, 1);
        expect_v(FR, 16'h0, 15); expect_v(PD, 16'h1, 15);
        expect_v(FR, 16'h1, 16); expect_v(PD, 16'h0, 16);
        for (int k = 0; k < 15; k++) begin
            tick(); bus.flip_req = 1'b0;
        end
        tick(); bus.addr_b = 5'd0;  expect_v(QB, 16'h003C);
        tick(); bus.addr_b = 5'd31; expect_v(QB, 16'h003C);

        // Back to front page 0, then prefill page 1 with known words
        tick(); bus.flip_req = 1'b1; expect_v(PD, 16'h1);
        tick(); bus.flip_req = 1'b0; expect_v(FR, 16'h0);
        tick(); bus.vblank = 1'b0;
        for (int w = 0; w < DA; w++) begin
            tick(); drv_wr(w, 16'h1000 + 16'(w), 2'b11);
        end
        tick(); bus.wr_a = 1'b0;

        // Reset after eight cleared words leaves the rest untouched
        tick(); bus.clear_start = 1'b1; bus.clear_value = 16'h5A5A;
        for (int k = 1; k <= 9; k++) expect_v(BZ, 16'h1, k);
        for (int k = 0; k < 9; k++) begin
            tick(); bus.clear_start = 1'b0;
        end
        reset = 1'b1; expect_v(BZ, 16'h0); expect_v(FR, 16'h0);
        tick(); reset = 1'b0; expect_v(BZ, 16'h0);
        for (int w = 0; w < DA; w++) begin
            tick(); bus.addr_a = w[3:0];
            expect_v(QA, (w < 8) ? 16'h5A5A : 16'h1000 + 16'(w));
        end
`else
        // Without the clear engine clear_start is ignored and writes proceed
        tick(); bus.clear_start = 1'b1; bus.clear_value = 16'h5A5A;
        drv_wr(2, 16'h2222, 2'b11); expect_v(BZ, 16'h0);
        tick(); bus.clear_start = 1'b0; bus.wr_a = 1'b0; bus.addr_a = 4'd2;
        expect_v(BZ, 16'h0); expect_v(QA, 16'h2222);
`endif

        // Reset overrides flip_req and clear_start in the same cycle
        tick(); reset = 1'b1; bus.flip_req = 1'b1; bus.clear_start = 1'b1; bus.vblank = 1'b0;
        expect_v(PD, 16'h0); expect_v(BZ, 16'h0); expect_v(QA, 16'h0000); expect_v(FR, 16'h0);
        tick(); reset = 1'b0; bus.flip_req = 1'b0; bus.clear_start = 1'b0;
        expect_v(PD, 16'h0); expect_v(BZ, 16'h0);

        for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard drain: %0d expectations left, required 0", sb.size());
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
